// File: rtl/full_adder_if.sv
// Operand/result bundle for the registered ripple-carry adder.
// The master drives operands; the adder (slave) returns the registered result.
interface full_adder_if #(
    parameter int WIDTH = 1
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin,
        input  out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin,
        output out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/full_adder.sv
// Registered ripple-carry adder: a chain of 1-bit full-adder cells computing
// {cout, sum} = a + b + cin, plus signed overflow, with one clock of latency.
module full_adder #(
    parameter int WIDTH = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    full_adder_if.slave  bus
);
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_next;

    assign carry[0] = bus.cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign sum_next[i]  = bus.a[i] ^ bus.b[i] ^ carry[i];
        assign carry[i+1]   = (bus.a[i] & bus.b[i]) | (carry[i] & (bus.a[i] ^ bus.b[i]));
    end

    // Result registers hold their value across idle cycles; only the
    // valid flag tracks in_valid edge by edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.sum       <= '0;
            bus.cout      <= 1'b0;
            bus.ovf       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.sum  <= sum_next;
                bus.cout <= carry[WIDTH];
                bus.ovf  <= carry[WIDTH] ^ carry[WIDTH-1];
            end
        end
    end
endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench: four adder widths driven with shared operands and
// compared against an arithmetic reference model of the registered result.
module tb_full_adder;
    localparam int N = 4;
    localparam int W [N] = '{1, 4, 8, 16};

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        in_valid_s;
    logic [63:0] a_s, b_s;
    logic        cin_s;

    full_adder_if #(.WIDTH(1))  if0 ();
    full_adder_if #(.WIDTH(4))  if1 ();
    full_adder_if #(.WIDTH(8))  if2 ();
    full_adder_if #(.WIDTH(16)) if3 ();

    full_adder #(.WIDTH(1))  dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    full_adder #(.WIDTH(4))  dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    full_adder #(.WIDTH(8))  dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    full_adder #(.WIDTH(16)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

    assign if0.in_valid = in_valid_s;  assign if0.a = a_s[0:0];  assign if0.b = b_s[0:0];  assign if0.cin = cin_s;
    assign if1.in_valid = in_valid_s;  assign if1.a = a_s[3:0];  assign if1.b = b_s[3:0];  assign if1.cin = cin_s;
    assign if2.in_valid = in_valid_s;  assign if2.a = a_s[7:0];  assign if2.b = b_s[7:0];  assign if2.cin = cin_s;
    assign if3.in_valid = in_valid_s;  assign if3.a = a_s[15:0]; assign if3.b = b_s[15:0]; assign if3.cin = cin_s;

    logic [63:0] o_sum [N];
    logic        o_cout [N], o_ovf [N], o_valid [N];
    assign o_sum[0] = 64'(if0.sum); assign o_cout[0] = if0.cout; assign o_ovf[0] = if0.ovf; assign o_valid[0] = if0.out_valid;
    assign o_sum[1] = 64'(if1.sum); assign o_cout[1] = if1.cout; assign o_ovf[1] = if1.ovf; assign o_valid[1] = if1.out_valid;
    assign o_sum[2] = 64'(if2.sum); assign o_cout[2] = if2.cout; assign o_ovf[2] = if2.ovf; assign o_valid[2] = if2.out_valid;
    assign o_sum[3] = 64'(if3.sum); assign o_cout[3] = if3.cout; assign o_ovf[3] = if3.ovf; assign o_valid[3] = if3.out_valid;

    // Expected registered state of each adder.
    logic [63:0] e_sum [N];
    logic        e_cout [N], e_ovf [N], e_valid [N];

    int total = 0;
    int bad   = 0;

    // Reference: plain integer addition, signed overflow from operand/result signs.
    function automatic void ref_add(input int w, input logic [63:0] a, input logic [63:0] b,
                                    input logic ci, output logic [63:0] s,
                                    output logic co, output logic ov);
        logic [64:0] mask;
        logic [64:0] full;
        mask = (65'd1 << w) - 65'd1;
        full = ({1'b0, a} & mask) + ({1'b0, b} & mask) + 65'(ci);
        s    = full[63:0] & mask[63:0];
        co   = full[w];
        ov   = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s.w%0d.sum", tag, W[i]),   o_sum[i],          e_sum[i]);
            check($sformatf("%s.w%0d.cout", tag, W[i]),  64'(o_cout[i]),    64'(e_cout[i]));
            check($sformatf("%s.w%0d.ovf", tag, W[i]),   64'(o_ovf[i]),     64'(e_ovf[i]));
            check($sformatf("%s.w%0d.valid", tag, W[i]), 64'(o_valid[i]),   64'(e_valid[i]));
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            e_sum[i] = '0; e_cout[i] = 1'b0; e_ovf[i] = 1'b0; e_valid[i] = 1'b0;
        end
    endtask

    task automatic drive(input logic v, input logic [63:0] a, input logic [63:0] b, input logic ci);
        in_valid_s = v; a_s = a; b_s = b; cin_s = ci;
    endtask

    // One rising edge, model update, then sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (in_valid_s) ref_add(W[i], a_s, b_s, cin_s, e_sum[i], e_cout[i], e_ovf[i]);
            e_valid[i] = in_valid_s;
        end
        #1;
    endtask

    int tt_sum  [8] = '{0, 1, 1, 0, 1, 0, 0, 1};
    int tt_cout [8] = '{0, 0, 0, 1, 0, 1, 1, 1};
    logic [63:0] s8_a [3] = '{64'h12, 64'hF0, 64'h80};
    logic [63:0] s8_b [3] = '{64'h34, 64'h20, 64'h80};
    logic        s8_c [3] = '{1'b0, 1'b1, 1'b0};
    logic [63:0] s8_s [3] = '{64'h46, 64'h11, 64'h00};
    logic        s8_o [3] = '{1'b0, 1'b1, 1'b1};
    logic        s8_v [3] = '{1'b0, 1'b0, 1'b1};

    initial begin
        rst_n = 1'b0;
        drive(1'b1, 64'hFFFF, 64'hFFFF, 1'b1);
        model_reset();
        #3;
        check_all("reset_init");
        @(posedge clk); #1;
        check_all("reset_held");
        @(negedge clk);
        rst_n = 1'b1;

        // WIDTH=1 truth table on consecutive edges.
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 64'(k[2]), 64'(k[1]), k[0]);
            step();
            check_all($sformatf("tt%0d", k));
            check($sformatf("tt%0d.sum_tab", k),  o_sum[0],        64'(tt_sum[k]));
            check($sformatf("tt%0d.cout_tab", k), 64'(o_cout[0]),  64'(tt_cout[k]));
            check($sformatf("tt%0d.valid_tab", k), 64'(o_valid[0]), 64'd1);
        end

        // Asynchronous reset between edges.
        drive(1'b1, 64'd1, 64'd1, 1'b1);
        step();
        check("pre_rst.sum", o_sum[0], 64'd1);
        check("pre_rst.cout", 64'(o_cout[0]), 64'd1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        step();
        model_reset();
        check_all("rst_low_edge");
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 64'd0, 64'd1, 1'b0);
        step();
        check_all("post_rst");
        check("post_rst.sum", o_sum[0], 64'd1);
        check("post_rst.cout", 64'(o_cout[0]), 64'd0);

        // Hold while idle.
        drive(1'b1, 64'd1, 64'd0, 1'b0);
        step();
        check_all("hold_load");
        drive(1'b0, 64'd1, 64'd1, 1'b1);
        step();
        check_all("hold_idle");
        check("hold.sum", o_sum[0], 64'd1);
        check("hold.cout", 64'(o_cout[0]), 64'd0);
        check("hold.valid", 64'(o_valid[0]), 64'd0);

        // WIDTH=8 carry ripple and signed overflow.
        drive(1'b1, 64'hFF, 64'h00, 1'b1);
        step();
        check_all("ripple");
        check("ripple.w8.sum", o_sum[2], 64'h00);
        check("ripple.w8.cout", 64'(o_cout[2]), 64'd1);
        check("ripple.w8.ovf", 64'(o_ovf[2]), 64'd0);
        drive(1'b1, 64'h7F, 64'h01, 1'b0);
        step();
        check_all("sovf");
        check("sovf.w8.sum", o_sum[2], 64'h80);
        check("sovf.w8.cout", 64'(o_cout[2]), 64'd0);
        check("sovf.w8.ovf", 64'(o_ovf[2]), 64'd1);

        // WIDTH=8 back-to-back stream.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, s8_a[k], s8_b[k], s8_c[k]);
            step();
            check_all($sformatf("stream%0d", k));
            check($sformatf("stream%0d.w8.sum", k),   o_sum[2],         s8_s[k]);
            check($sformatf("stream%0d.w8.cout", k),  64'(o_cout[2]),   64'(s8_o[k]));
            check($sformatf("stream%0d.w8.ovf", k),   64'(o_ovf[2]),    64'(s8_v[k]));
            check($sformatf("stream%0d.w8.valid", k), 64'(o_valid[2]),  64'd1);
        end

        // All-ones boundary and all-zeros.
        drive(1'b1, 64'hFFFF, 64'hFFFF, 1'b1);
        step();
        check_all("ones");
        drive(1'b1, 64'd0, 64'd0, 1'b0);
        step();
        check_all("zeros");

        // Random regression with sparse idle cycles.
        for (int n = 0; n < 10000; n++) begin
            drive($urandom_range(0, 7) != 0, {$urandom, $urandom}, {$urandom, $urandom},
                  1'($urandom_range(0, 1)));
            step();
            check_all("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
